reg_file_ctx: RTL and testbench

//  Parametrised 2-read/1-write register file with dedicated COUT register and a

---
 rtl/reg_file_ctx.sv | 107 ++++++++++
 tb/tb_reg_file_ctx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_ctx.sv
// 2-read/1-write register file with dedicated COUT register and a shadow
// snapshot bank for context save/restore. Optional macro: RF_BYPASS_EN.
module reg_file_ctx #(
  parameter int AW       = 3,
  parameter int DW       = 8,
  parameter int COUT_IDX = 2**AW-1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] rt,
  input  logic          write_enable,
  input  logic [DW-1:0] write_data,
  input  logic          cout_write_enable,
  input  logic [DW-1:0] cout_data,
  input  logic          save_req,
  input  logic          restore_req,
  output logic [DW-1:0] rs_val_o,
  output logic [DW-1:0] rt_val_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          snap_valid_o,
  output logic          err_o
);

  localparam int          N      = 2**AW;
  localparam logic [AW-1:0] COUT_A = AW'(COUT_IDX);
  localparam logic [AW-1:0] LAST_A = AW'(N-1);

  typedef enum logic [1:0] {IDLE, SAVE, RESTORE} state_t;

  state_t        state, state_next;
  logic [AW-1:0] idx;
  logic [DW-1:0] rf     [N];
  logic [DW-1:0] shadow [N];
  logic          idle;
  logic          last_word;

  assign idle      = (state == IDLE);
  assign last_word = (idx == LAST_A);
  assign busy_o    = !idle;

  // NOTE: combinational next-state gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (save_req)                         state_next = SAVE;
        else if (restore_req && snap_valid_o) state_next = RESTORE;
      end
      SAVE, RESTORE: if (last_word) state_next = IDLE;
      default:       state_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      snap_valid_o <= 1'b0;
    end else begin
      state  <= state_next;
      done_o <= !idle && last_word;
      err_o  <= idle && !save_req && restore_req && !snap_valid_o;
      idx    <= (!idle && !last_word) ? idx + 1'b1 : '0;
      // A partially written snapshot must never look valid.
      if (idle && save_req)
        snap_valid_o <= 1'b0;
      else if (state == SAVE && last_word)
        snap_valid_o <= 1'b1;
    end
  end

  // Live file: core/ALU writes only while idle, restore copies one word per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) rf[i] <= '0;
    end else if (state == RESTORE) begin
      rf[idx] <= shadow[idx];
    end else if (idle) begin
      if (write_enable)      rf[rs]     <= write_data;
      if (cout_write_enable) rf[COUT_A] <= cout_data;
    end
  end

  // NOTE: the shadow bank is plain storage with no reset; snap_valid_o guards its use.
  always_ff @(posedge clk) begin
    if (state == SAVE) shadow[idx] <= rf[idx];
  end

  always_comb begin
    rs_val_o = rf[rs];
    rt_val_o = rf[rt];
`ifdef RF_BYPASS_EN
    if (idle) begin
      if (write_enable)                     rs_val_o = write_data;
      if (write_enable && rt == rs)         rt_val_o = write_data;
      if (cout_write_enable && rs == COUT_A) rs_val_o = cout_data;
      if (cout_write_enable && rt == COUT_A) rt_val_o = cout_data;
    end
`endif
  end

endmodule

// File: tb/tb_reg_file_ctx.sv
// Scoreboard bench for reg_file_ctx: stimulus pushes expected per-cycle
// observations from a behavioural model; a negedge monitor pops and compares.
module tb_reg_file_ctx;
  localparam int AW = 3;
  localparam int DW = 8;
  localparam int N  = 8;
  localparam int CI = 7;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] rs = '0, rt = '0;
  logic          write_enable = 1'b0, cout_write_enable = 1'b0;
  logic [DW-1:0] write_data = '0, cout_data = '0;
  logic          save_req = 1'b0, restore_req = 1'b0;
  logic [DW-1:0] rs_val_o, rt_val_o;
  logic          busy_o, done_o, snap_valid_o, err_o;

  reg_file_ctx #(.AW(AW), .DW(DW), .COUT_IDX(CI)) dut (
    .clk(clk), .reset(reset), .rs(rs), .rt(rt),
    .write_enable(write_enable), .write_data(write_data),
    .cout_write_enable(cout_write_enable), .cout_data(cout_data),
    .save_req(save_req), .restore_req(restore_req),
    .rs_val_o(rs_val_o), .rt_val_o(rt_val_o), .busy_o(busy_o),
    .done_o(done_o), .snap_valid_o(snap_valid_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] rs_v;
    logic [DW-1:0] rt_v;
    logic          busy;
    logic          done;
    logic          snap;
    logic          err;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: register arrays plus the time an operation was accepted.
  logic [DW-1:0] m_rf [N];
  logic [DW-1:0] m_sh [N];
  bit m_busy, m_done, m_err, m_snap, op_save;
  int cyc = 0;
  int op_start = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  obs_t mon_act, mon_exp;
  always @(negedge clk) begin
    if (!reset) begin
      mon_act = '{rs_val_o, rt_val_o, busy_o, done_o, snap_valid_o, err_o};
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty at cycle %0d", cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        checks++;
        if (mon_act !== mon_exp) begin
          failures++;
          $display("FAIL obs cycle %0d: got rs=%h rt=%h busy=%b done=%b snap=%b err=%b expected rs=%h rt=%h busy=%b done=%b snap=%b err=%b",
                   cyc, mon_act.rs_v, mon_act.rt_v, mon_act.busy, mon_act.done, mon_act.snap, mon_act.err,
                   mon_exp.rs_v, mon_exp.rt_v, mon_exp.busy, mon_exp.done, mon_exp.snap, mon_exp.err);
        end
      end
    end
  end

  function automatic obs_t expect_now();
    obs_t e;
    e.rs_v = m_rf[rs];
    e.rt_v = m_rf[rt];
`ifdef RF_BYPASS_EN
    if (!m_busy) begin
      if (write_enable)                           e.rs_v = write_data;
      if (write_enable && rt == rs)               e.rt_v = write_data;
      if (cout_write_enable && int'(rs) == CI)    e.rs_v = cout_data;
      if (cout_write_enable && int'(rt) == CI)    e.rt_v = cout_data;
    end
`endif
    e.busy = m_busy;
    e.done = m_done;
    e.snap = m_snap;
    e.err  = m_err;
    return e;
  endfunction

  // Advance the model across one rising edge using the inputs held at that edge.
  task automatic model_step();
    int i;
    cyc++;
    m_done = 0;
    m_err  = 0;
    if (m_busy) begin
      i = cyc - op_start - 1;
      if (op_save) m_sh[i] = m_rf[i];
      else         m_rf[i] = m_sh[i];
      if (i == N-1) begin
        m_busy = 0;
        m_done = 1;
        if (op_save) m_snap = 1;
      end
    end else begin
      if (write_enable)      m_rf[rs] = write_data;
      if (cout_write_enable) m_rf[CI] = cout_data;
      if (save_req) begin
        m_busy = 1; op_save = 1; op_start = cyc; m_snap = 0;
      end else if (restore_req) begin
        if (m_snap) begin
          m_busy = 1; op_save = 0; op_start = cyc;
        end else begin
          m_err = 1;
        end
      end
    end
  endtask

  task automatic do_cycle(input logic we_i, input logic [AW-1:0] rs_i, input logic [AW-1:0] rt_i,
                          input logic [DW-1:0] wd_i, input logic cwe_i, input logic [DW-1:0] cd_i,
                          input logic sr_i, input logic rr_i);
    write_enable = we_i; rs = rs_i; rt = rt_i; write_data = wd_i;
    cout_write_enable = cwe_i; cout_data = cd_i;
    save_req = sr_i; restore_req = rr_i;
    exp_q.push_back(expect_now());
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) do_cycle(1'b0, AW'(k), AW'(k + 3), '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset applied mid-cycle; outputs are checked before any edge.
  task automatic apply_reset();
    write_enable = 0; cout_write_enable = 0; save_req = 0; restore_req = 0;
    reset = 1'b1;
    #1;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_snap", 32'(snap_valid_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err",  32'(err_o), 32'd0);
    for (int a = 0; a < N; a++) begin
      rs = AW'(a); rt = AW'(N - 1 - a);
      #0.1;
      check($sformatf("rst_rf%0d", a), 32'(rs_val_o), 32'd0);
    end
    for (int a = 0; a < N; a++) m_rf[a] = '0;
    m_busy = 0; m_done = 0; m_err = 0; m_snap = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < N; a++) begin m_rf[a] = '0; m_sh[a] = '0; end
    @(posedge clk); #1;
    apply_reset();

    // Restore with no snapshot: error pulse, no busy, RF untouched.
    do_cycle(1'b1, 3'd4, 3'd4, 8'h3C, 1'b0, '0, 1'b0, 1'b0);
    do_cycle(1'b0, 3'd4, 3'd0, '0, 1'b0, '0, 1'b0, 1'b1);
    idle_cycles(2);

    // Reset in the middle of a save (idx == 3).
    do_cycle(1'b0, 3'd0, 3'd1, '0, 1'b0, '0, 1'b1, 1'b0);
    idle_cycles(3);
    apply_reset();

    // Write and read the same address in one cycle, then read it back.
    do_cycle(1'b1, 3'd2, 3'd2, 8'hA5, 1'b0, '0, 1'b0, 1'b0);
    do_cycle(1'b0, 3'd2, 3'd2, '0, 1'b0, '0, 1'b0, 1'b0);

    // COUT write beats core write to the same register.
    do_cycle(1'b1, 3'd7, 3'd7, 8'h11, 1'b1, 8'h01, 1'b0, 1'b0);
    do_cycle(1'b0, 3'd7, 3'd7, '0, 1'b0, '0, 1'b0, 1'b0);

    // Fill, save, clobber, restore, read back every word.
    for (int a = 0; a < N; a++) do_cycle(1'b1, AW'(a), AW'(a), DW'(a + 1), 1'b0, '0, 1'b0, 1'b0);
    do_cycle(1'b0, 3'd0, 3'd1, '0, 1'b0, '0, 1'b1, 1'b0);
    idle_cycles(N);
    for (int a = 0; a < N; a++) do_cycle(1'b1, AW'(a), AW'(a), '0, 1'b0, '0, 1'b0, 1'b0);
    do_cycle(1'b0, 3'd0, 3'd1, '0, 1'b0, '0, 1'b0, 1'b1);
    idle_cycles(N + 1);
    for (int a = 0; a < N; a++) do_cycle(1'b0, AW'(a), AW'(N - 1 - a), '0, 1'b0, '0, 1'b0, 1'b0);

    // Save and restore together: save wins; writes and requests during busy dropped.
    do_cycle(1'b0, 3'd0, 3'd0, '0, 1'b0, '0, 1'b1, 1'b1);
    for (int a = 0; a < N; a++) do_cycle(1'b1, AW'(a), AW'(a), 8'hEE, 1'b1, 8'hDD, a == 2, a == 5);
    idle_cycles(2);

    // Back-to-back: restore requested in the done cycle.
    do_cycle(1'b0, 3'd0, 3'd0, '0, 1'b0, '0, 1'b1, 1'b0);
    idle_cycles(N - 1);
    do_cycle(1'b0, 3'd1, 3'd2, '0, 1'b0, '0, 1'b0, 1'b0);
    do_cycle(1'b0, 3'd1, 3'd2, '0, 1'b0, '0, 1'b0, 1'b1);
    idle_cycles(N + 1);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      do_cycle(1'($urandom_range(0, 1)), AW'($urandom), AW'($urandom), DW'($urandom),
               $urandom_range(0, 9) < 3, DW'($urandom),
               $urandom_range(0, 24) == 0, $urandom_range(0, 14) == 0);
      if (k == 1500) apply_reset();
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
